// File: rtl/pe_psum_accum_drain_if.sv
// pe_psum_accum_drain_if: config, dual psum inputs, router output and status of the psum drain.
interface pe_psum_accum_drain_if #(
    parameter int ADDR_W = 10,
    parameter int CNT_W = 8
);
    logic                     cfg_start;
    logic [CNT_W-1:0]         cfg_num_psum;
    logic [ADDR_W-1:0]        cfg_base_addr;
    logic                     psum_in_valid;
    logic                     psum_in_ready;
    logic signed [20:0]       psum_in_data;
    logic                     psum_prev_valid;
    logic                     psum_prev_ready;
    logic signed [20:0]       psum_prev_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [20:0]       out_data;
    logic [ADDR_W-1:0]        out_addr;
    logic                     busy;
    logic                     done;
    modport master (
        output cfg_start, cfg_num_psum, cfg_base_addr,
        output psum_in_valid, psum_in_data, psum_prev_valid, psum_prev_data, out_ready,
        input  psum_in_ready, psum_prev_ready, out_valid, out_data, out_addr, busy, done
    );
    modport slave (
        input  cfg_start, cfg_num_psum, cfg_base_addr,
        input  psum_in_valid, psum_in_data, psum_prev_valid, psum_prev_data, out_ready,
        output psum_in_ready, psum_prev_ready, out_valid, out_data, out_addr, busy, done
    );
endinterface

// File: rtl/pe_psum_accum_drain.sv
// pe_psum_accum_drain: joins local and upstream psums, adds them and forwards the sum with a GLB address.
// Define PSUM_DRAIN_SAT_EN to saturate the sum to 21 bits instead of wrapping.
module pe_psum_accum_drain #(
    parameter int ADDR_W = 10,
    parameter int CNT_W = 8
) (
    input logic clock,
    input logic reset,
    pe_psum_accum_drain_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    idx_q, idx_d, num_q, num_d;
    logic [ADDR_W-1:0]   base_q, base_d, out_addr_q, out_addr_d;
    logic signed [20:0]  out_data_q, out_data_d, sum_21;
    logic signed [21:0]  sum_22;
    logic                out_valid_q, out_valid_d, done_q, done_d;
    logic                out_free, fire, last, start_ok;

    assign out_free = ~out_valid_q | bus.out_ready;
    assign fire     = (state_q == RUN) & bus.psum_in_valid & bus.psum_prev_valid & out_free;
    assign last     = idx_q == num_q - CNT_W'(1);
    assign start_ok = (state_q == IDLE) & bus.cfg_start;
    assign sum_22   = {bus.psum_in_data[20], bus.psum_in_data} + {bus.psum_prev_data[20], bus.psum_prev_data};
`ifdef PSUM_DRAIN_SAT_EN
    // Sign bits disagree only on overflow; bit 21 tells the direction.
    assign sum_21 = (sum_22[21] != sum_22[20]) ? (sum_22[21] ? 21'sh100000 : 21'sh0FFFFF) : sum_22[20:0];
`else
    assign sum_21 = sum_22[20:0];
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            num_q       <= '0;
            base_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            num_q       <= num_d;
            base_q      <= base_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = (state_q == IDLE)  ? (bus.cfg_start ? ((bus.cfg_num_psum == '0) ? FLUSH : RUN) : IDLE) :
                  (state_q == RUN)   ? ((fire & last) ? FLUSH : RUN) :
                  (state_q == FLUSH) ? (out_free ? IDLE : FLUSH) : IDLE;
    end

    always_comb begin
        num_d       = start_ok ? bus.cfg_num_psum : num_q;
        base_d      = start_ok ? bus.cfg_base_addr : base_q;
        idx_d       = start_ok ? '0 : fire ? idx_q + CNT_W'(1) : idx_q;
        out_valid_d = fire | (out_valid_q & ~bus.out_ready);
        out_data_d  = fire ? sum_21 : out_data_q;
        out_addr_d  = fire ? base_q + ADDR_W'(idx_q) : out_addr_q;
        done_d      = (state_q == FLUSH) & out_free;
    end

    assign bus.psum_in_ready   = fire;
    assign bus.psum_prev_ready = fire;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_data        = out_data_q;
    assign bus.out_addr        = out_addr_q;
    assign bus.busy            = state_q != IDLE;
    assign bus.done            = done_q;
endmodule
